// File: rtl/ascon_ctrl_fsm.sv
// Sequencing FSM for one ASCON-128 encryption: drives the round counter, strobes the state datapath.
// Latency: start accepted at edge 0 -> LOAD cycle 1, 12 init rounds, first block_ready_o in cycle 15.
// Backpressure: WAIT_BLK holds (counter cleared, no permutation) until block_valid_i; optional abort via ASCON_CTRL_ABORT_EN.
module ascon_ctrl_fsm #(
    parameter int N_BITS   = 5,
    parameter int ROUNDS_A = 12,
    parameter int ROUNDS_B = 6
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic              block_valid_i,
    input  logic              block_last_i,
`ifdef ASCON_CTRL_ABORT_EN
    input  logic              abort_i,
`endif
    output logic              block_ready_o,
    input  logic [N_BITS:0]   cpt_i,
    output logic              cpt_en_o,
    output logic              cpt_init_o,
    output logic [3:0]        round_o,
    output logic              perm_en_o,
    output logic              state_load_o,
    output logic              key_xor_init_o,
    output logic              data_xor_o,
    output logic              key_xor_final_o,
    output logic              busy_o,
    output logic              done_o
);

    typedef enum logic [3:0] {
        IDLE,
        LOAD,
        INIT_R,
        INIT_KEY,
        WAIT_BLK,
        MID_R,
        FIN_KEY,
        FIN_R,
        TAG
    } state_t;

    // Last counter value of each permutation, and the round-constant offset
    // so that a shortened permutation uses the final constants of the table.
    localparam logic [N_BITS:0] LAST_A = (N_BITS + 1)'(ROUNDS_A - 1);
    localparam logic [N_BITS:0] LAST_B = (N_BITS + 1)'(ROUNDS_B - 1);
    localparam logic [3:0]      OFF_A  = 4'(12 - ROUNDS_A);
    localparam logic [3:0]      OFF_B  = 4'(12 - ROUNDS_B);

    state_t state;
    state_t state_nxt;

    // State register with synchronous reset.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and output decode; everything Moore except the block handshake.
    always_comb begin
        state_nxt       = state;
        block_ready_o   = 1'b0;
        cpt_en_o        = 1'b0;
        cpt_init_o      = 1'b0;
        round_o         = 4'd0;
        perm_en_o       = 1'b0;
        state_load_o    = 1'b0;
        key_xor_init_o  = 1'b0;
        data_xor_o      = 1'b0;
        key_xor_final_o = 1'b0;
        busy_o          = 1'b1;
        done_o          = 1'b0;

        case (state)
            IDLE: begin
                busy_o = 1'b0;
                if (start_i) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                state_load_o = 1'b1;
                cpt_en_o     = 1'b1;
                cpt_init_o   = 1'b1;
                state_nxt    = INIT_R;
            end
            INIT_R: begin
                perm_en_o = 1'b1;
                cpt_en_o  = 1'b1;
                round_o   = cpt_i[3:0] + OFF_A;
                // ">=" so a counter that overshoots still terminates the phase
                if (cpt_i >= LAST_A) begin
                    state_nxt = INIT_KEY;
                end
            end
            INIT_KEY: begin
                key_xor_init_o = 1'b1;
                cpt_en_o       = 1'b1;
                cpt_init_o     = 1'b1;
                state_nxt      = WAIT_BLK;
            end
            WAIT_BLK: begin
                block_ready_o = 1'b1;
                cpt_en_o      = 1'b1;
                cpt_init_o    = 1'b1;
                if (block_valid_i) begin
                    data_xor_o = 1'b1;
                    state_nxt  = block_last_i ? FIN_KEY : MID_R;
                end
            end
            MID_R: begin
                perm_en_o = 1'b1;
                cpt_en_o  = 1'b1;
                round_o   = cpt_i[3:0] + OFF_B;
                if (cpt_i >= LAST_B) begin
                    state_nxt = WAIT_BLK;
                end
            end
            FIN_KEY: begin
                key_xor_final_o = 1'b1;
                cpt_en_o        = 1'b1;
                cpt_init_o      = 1'b1;
                state_nxt       = FIN_R;
            end
            FIN_R: begin
                perm_en_o = 1'b1;
                cpt_en_o  = 1'b1;
                round_o   = cpt_i[3:0] + OFF_A;
                if (cpt_i >= LAST_A) begin
                    state_nxt = TAG;
                end
            end
            TAG: begin
                done_o    = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

`ifdef ASCON_CTRL_ABORT_EN
        // Abort drops the operation: clear the counter, never report a tag.
        if (abort_i && (state != IDLE)) begin
            state_nxt  = IDLE;
            cpt_en_o   = 1'b1;
            cpt_init_o = 1'b1;
            done_o     = 1'b0;
        end
`endif
    end

endmodule

// File: tb/tb_ascon_ctrl_fsm.sv
// Testbench for ascon_ctrl_fsm: per-cycle output words compared against a schedule-based model.
// Latency: model places every strobe at its absolute cycle from start/acceptance times.
// Backpressure: stimulus tables drive block_valid_i gaps; round counter modelled alongside.
module tb_ascon_ctrl_fsm;

    localparam int RA   = 12;
    localparam int RB   = 6;
    localparam int MAXN = 400;

    // output word bit positions
    localparam int B_DONE = 0;
    localparam int B_BUSY = 1;
    localparam int B_KXF  = 2;
    localparam int B_DX   = 3;
    localparam int B_KXI  = 4;
    localparam int B_LOAD = 5;
    localparam int B_PERM = 6;
    localparam int B_INIT = 11;
    localparam int B_EN   = 12;
    localparam int B_RDY  = 13;

    logic       clock_i = 1'b0;
    logic       reset_i = 1'b1;
    logic       start_i = 1'b0;
    logic       block_valid_i = 1'b0;
    logic       block_last_i = 1'b0;
    logic       abort_i = 1'b0;
    logic [5:0] cpt_i = 6'd0;
    logic       block_ready_o, cpt_en_o, cpt_init_o, perm_en_o, state_load_o;
    logic       key_xor_init_o, data_xor_o, key_xor_final_o, busy_o, done_o;
    logic [3:0] round_o;

    ascon_ctrl_fsm #(.N_BITS(5), .ROUNDS_A(RA), .ROUNDS_B(RB)) dut (
        .clock_i         (clock_i),
        .reset_i         (reset_i),
        .start_i         (start_i),
        .block_valid_i   (block_valid_i),
        .block_last_i    (block_last_i),
`ifdef ASCON_CTRL_ABORT_EN
        .abort_i         (abort_i),
`endif
        .block_ready_o   (block_ready_o),
        .cpt_i           (cpt_i),
        .cpt_en_o        (cpt_en_o),
        .cpt_init_o      (cpt_init_o),
        .round_o         (round_o),
        .perm_en_o       (perm_en_o),
        .state_load_o    (state_load_o),
        .key_xor_init_o  (key_xor_init_o),
        .data_xor_o      (data_xor_o),
        .key_xor_final_o (key_xor_final_o),
        .busy_o          (busy_o),
        .done_o          (done_o)
    );

    always #5 clock_i = ~clock_i;

    // Round counter (compteur_Nbits behaviour): clear on init, else count while enabled.
    always @(posedge clock_i) begin
        if (reset_i) cpt_i <= 6'd0;
        else if (cpt_en_o) cpt_i <= cpt_init_o ? 6'd0 : cpt_i + 6'd1;
    end

    logic [13:0] obs_now;
    assign obs_now = {block_ready_o, cpt_en_o, cpt_init_o, round_o, perm_en_o, state_load_o,
                      key_xor_init_o, data_xor_o, key_xor_final_o, busy_o, done_o};

    logic        st_s [MAXN];
    logic        va_s [MAXN];
    logic        la_s [MAXN];
    logic        rs_s [MAXN];
    logic        ab_s [MAXN];
    logic [13:0] exp_w [MAXN];
    logic [13:0] obs_w [MAXN];
    int          lim;
    int          nvec = 0;
    int          nerr = 0;

    // Expected-word builders.
    function automatic logic [13:0] wbits(input int b0, input int b1, input int b2, input int b3);
        logic [13:0] w = '0;
        w[B_BUSY] = 1'b1;
        if (b0 >= 0) w[b0] = 1'b1;
        if (b1 >= 0) w[b1] = 1'b1;
        if (b2 >= 0) w[b2] = 1'b1;
        if (b3 >= 0) w[b3] = 1'b1;
        return w;
    endfunction

    function automatic logic [13:0] wround(input int r);
        logic [13:0] w = wbits(B_PERM, B_EN, -1, -1);
        logic [3:0]  rv = r[3:0];
        w[10:7] = rv;
        return w;
    endfunction

    function automatic void put(input int c, input logic [13:0] w);
        if (c <= lim) exp_w[c] = w;
    endfunction

    // Schedule model: each operation is laid out from its start cycle and the
    // cycles at which blocks are accepted; reset/abort cuts it short.
    function automatic void build(input int n);
        int k, stop, t, e, fin;
        for (int c = 0; c < n; c++) exp_w[c] = '0;
        k = 0;
        while (k < n) begin
            if (rs_s[k] || !st_s[k]) begin
                k++;
                continue;
            end
            stop = n - 1;
            for (int c = n - 1; c > k; c--) if (rs_s[c] || ab_s[c]) stop = c;
            lim = stop;
            put(k + 1, wbits(B_LOAD, B_EN, B_INIT, -1));
            for (int i = 0; i < RA; i++) put(k + 2 + i, wround(12 - RA + i));
            put(k + 2 + RA, wbits(B_KXI, B_EN, B_INIT, -1));
            t = k + 3 + RA;
            e = lim;
            while (1) begin
                while (t <= lim && !va_s[t]) begin
                    put(t, wbits(B_RDY, B_EN, B_INIT, -1));
                    t++;
                end
                if (t > lim) begin
                    e = lim;
                    break;
                end
                put(t, wbits(B_RDY, B_EN, B_INIT, B_DX));
                if (la_s[t]) begin
                    put(t + 1, wbits(B_KXF, B_EN, B_INIT, -1));
                    for (int i = 0; i < RA; i++) put(t + 2 + i, wround(12 - RA + i));
                    put(t + 2 + RA, wbits(B_DONE, -1, -1, -1));
                    e = t + 2 + RA;
                    break;
                end
                for (int i = 0; i < RB; i++) put(t + 1 + i, wround(12 - RB + i));
                t = t + RB + 1;
            end
            fin = (stop < e) ? stop : e;
            if (stop <= e && ab_s[stop] && !rs_s[stop]) begin
                exp_w[stop][B_EN]   = 1'b1;
                exp_w[stop][B_INIT] = 1'b1;
                exp_w[stop][B_DONE] = 1'b0;
            end
            k = fin + 1;
        end
    endfunction

    function automatic void clear_stim();
        for (int c = 0; c < MAXN; c++) begin
            st_s[c] = 1'b0; va_s[c] = 1'b0; la_s[c] = 1'b0; rs_s[c] = 1'b0; ab_s[c] = 1'b0;
        end
    endfunction

    task automatic do_reset();
        reset_i = 1'b1; start_i = 1'b0; block_valid_i = 1'b0; block_last_i = 1'b0; abort_i = 1'b0;
        repeat (2) @(posedge clock_i);
        #1;
    endtask

    // Drive the stimulus tables cycle by cycle and record the DUT outputs mid-cycle.
    task automatic run(input int n);
        for (int c = 0; c < n; c++) begin
            reset_i = rs_s[c]; start_i = st_s[c]; block_valid_i = va_s[c];
            block_last_i = la_s[c]; abort_i = ab_s[c];
            @(negedge clock_i);
            obs_w[c] = obs_now;
            @(posedge clock_i);
            #1;
        end
        reset_i = 1'b0; start_i = 1'b0; block_valid_i = 1'b0; abort_i = 1'b0;
    endtask

    task automatic test_reset();
        int n = 40;
        clear_stim();
        for (int c = 0; c < n; c++) begin st_s[c] = 1'b1; va_s[c] = 1'b1; la_s[c] = 1'b1; end
        rs_s[5] = 1'b1; rs_s[6] = 1'b1; rs_s[7] = 1'b1;
        do_reset();
        run(n);
        build(n);
        nvec++;
        if (obs_w[0] !== 14'd0) begin
            nerr++; $display("FAIL reset_idle got %h want 0000", obs_w[0]);
        end
        for (int c = 6; c <= 8; c++) begin
            nvec++;
            if (obs_w[c] !== 14'd0) begin
                nerr++; $display("FAIL reset_hold cycle %0d got %h want 0000", c, obs_w[c]);
            end
        end
        nvec++;
        if (obs_w[9][B_LOAD] !== 1'b1) begin
            nerr++; $display("FAIL reset_restart load got %b want 1", obs_w[9][B_LOAD]);
        end
        for (int c = 0; c < n; c++) begin
            nvec++;
            if (obs_w[c] !== exp_w[c]) begin
                nerr++; $display("FAIL reset cycle %0d got %h want %h", c, obs_w[c], exp_w[c]);
            end
        end
    endtask

    task automatic test_single_last();
        int n = 40;
        int ndone = 0;
        clear_stim();
        st_s[0] = 1'b1;
        for (int c = 0; c < n; c++) begin va_s[c] = 1'b1; la_s[c] = 1'b1; end
        do_reset();
        run(n);
        build(n);
        for (int c = 0; c < n; c++) ndone += int'(obs_w[c][B_DONE]);
        nvec++;
        if (obs_w[29][B_DONE] !== 1'b1 || ndone != 1) begin
            nerr++; $display("FAIL single_done c29=%b count=%0d want 1/1", obs_w[29][B_DONE], ndone);
        end
        nvec++;
        if (obs_w[15][B_DX] !== 1'b1 || obs_w[16][B_KXF] !== 1'b1 || obs_w[14][B_KXI] !== 1'b1) begin
            nerr++; $display("FAIL single_strobes dx=%b kxf=%b kxi=%b want 111",
                             obs_w[15][B_DX], obs_w[16][B_KXF], obs_w[14][B_KXI]);
        end
        nvec++;
        if (obs_w[28][10:7] !== 4'd11 || obs_w[30][B_BUSY] !== 1'b0) begin
            nerr++; $display("FAIL single_tail round28=%0d busy30=%b want 11/0",
                             obs_w[28][10:7], obs_w[30][B_BUSY]);
        end
        for (int c = 0; c < n; c++) begin
            nvec++;
            if (obs_w[c] !== exp_w[c]) begin
                nerr++; $display("FAIL single cycle %0d got %h want %h", c, obs_w[c], exp_w[c]);
            end
        end
    endtask

    task automatic test_two_blocks();
        int n = 45;
        clear_stim();
        st_s[0] = 1'b1;
        for (int c = 0; c < n; c++) begin va_s[c] = 1'b1; la_s[c] = (c >= 16); end
        do_reset();
        run(n);
        build(n);
        nvec++;
        if (obs_w[16][10:7] !== 4'd6 || obs_w[21][10:7] !== 4'd11 || obs_w[22][B_RDY] !== 1'b1) begin
            nerr++; $display("FAIL two_mid r16=%0d r21=%0d rdy22=%b want 6/11/1",
                             obs_w[16][10:7], obs_w[21][10:7], obs_w[22][B_RDY]);
        end
        nvec++;
        if (obs_w[36][B_DONE] !== 1'b1) begin
            nerr++; $display("FAIL two_done got %b want 1", obs_w[36][B_DONE]);
        end
        for (int c = 0; c < n; c++) begin
            nvec++;
            if (obs_w[c] !== exp_w[c]) begin
                nerr++; $display("FAIL two cycle %0d got %h want %h", c, obs_w[c], exp_w[c]);
            end
        end
    endtask

    task automatic test_backpressure();
        int n = 50;
        clear_stim();
        st_s[0] = 1'b1;
        for (int c = 25; c < n; c++) begin va_s[c] = 1'b1; la_s[c] = 1'b1; end
        do_reset();
        run(n);
        build(n);
        for (int c = 15; c < 25; c++) begin
            nvec++;
            if (obs_w[c] !== 14'h3802) begin
                nerr++; $display("FAIL backpressure cycle %0d got %h want 3802", c, obs_w[c]);
            end
        end
        for (int c = 0; c < n; c++) begin
            nvec++;
            if (obs_w[c] !== exp_w[c]) begin
                nerr++; $display("FAIL bp cycle %0d got %h want %h", c, obs_w[c], exp_w[c]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int n = 60;
        int ndone = 0;
        clear_stim();
        st_s[0] = 1'b1; st_s[21] = 1'b1; rs_s[20] = 1'b1;
        for (int c = 0; c < n; c++) begin va_s[c] = 1'b1; la_s[c] = 1'b1; end
        do_reset();
        run(n);
        build(n);
        for (int c = 0; c < 50; c++) ndone += int'(obs_w[c][B_DONE]);
        nvec++;
        if (ndone != 0 || obs_w[21] !== 14'd0 || obs_w[50][B_DONE] !== 1'b1) begin
            nerr++; $display("FAIL reset_mid early_done=%0d idle21=%h done50=%b want 0/0000/1",
                             ndone, obs_w[21], obs_w[50][B_DONE]);
        end
        for (int c = 0; c < n; c++) begin
            nvec++;
            if (obs_w[c] !== exp_w[c]) begin
                nerr++; $display("FAIL reset_mid cycle %0d got %h want %h", c, obs_w[c], exp_w[c]);
            end
        end
    endtask

    task automatic test_start_held();
        int n = 70;
        int ndone = 0;
        clear_stim();
        for (int c = 0; c < n; c++) begin st_s[c] = 1'b1; va_s[c] = 1'b1; la_s[c] = 1'b1; end
        do_reset();
        run(n);
        build(n);
        for (int c = 0; c < 59; c++) ndone += int'(obs_w[c][B_DONE]);
        nvec++;
        if (ndone != 1 || obs_w[30] !== 14'd0 || obs_w[31][B_LOAD] !== 1'b1) begin
            nerr++; $display("FAIL start_held dones=%0d idle30=%h load31=%b want 1/0000/1",
                             ndone, obs_w[30], obs_w[31][B_LOAD]);
        end
        for (int c = 0; c < n; c++) begin
            nvec++;
            if (obs_w[c] !== exp_w[c]) begin
                nerr++; $display("FAIL held cycle %0d got %h want %h", c, obs_w[c], exp_w[c]);
            end
        end
    endtask

`ifdef ASCON_CTRL_ABORT_EN
    task automatic test_abort();
        int n = 40;
        int ndone = 0;
        clear_stim();
        st_s[0] = 1'b1; ab_s[5] = 1'b1;
        for (int c = 0; c < n; c++) begin va_s[c] = 1'b1; la_s[c] = 1'b1; end
        do_reset();
        run(n);
        build(n);
        for (int c = 0; c < n; c++) ndone += int'(obs_w[c][B_DONE]);
        nvec++;
        if (obs_w[6] !== 14'd0 || obs_w[5][B_INIT] !== 1'b1 || ndone != 0) begin
            nerr++; $display("FAIL abort idle6=%h init5=%b dones=%0d want 0000/1/0",
                             obs_w[6], obs_w[5][B_INIT], ndone);
        end
        for (int c = 0; c < n; c++) begin
            nvec++;
            if (obs_w[c] !== exp_w[c]) begin
                nerr++; $display("FAIL abort cycle %0d got %h want %h", c, obs_w[c], exp_w[c]);
            end
        end
    endtask
`endif

    task automatic test_random();
        int n = 300;
        for (int it = 0; it < 3; it++) begin
            clear_stim();
            for (int c = 0; c < n; c++) begin
                st_s[c] = ($urandom_range(0, 3) == 0);
                va_s[c] = ($urandom_range(0, 1) == 1);
                la_s[c] = ($urandom_range(0, 3) == 0);
                rs_s[c] = ($urandom_range(0, 149) == 0);
`ifdef ASCON_CTRL_ABORT_EN
                ab_s[c] = ($urandom_range(0, 59) == 0);
`endif
            end
            do_reset();
            run(n);
            build(n);
            for (int c = 0; c < n; c++) begin
                nvec++;
                if (obs_w[c] !== exp_w[c]) begin
                    nerr++; $display("FAIL random it%0d cycle %0d got %h want %h", it, c, obs_w[c], exp_w[c]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_last();
        test_two_blocks();
        test_backpressure();
        test_reset_mid();
        test_start_held();
`ifdef ASCON_CTRL_ABORT_EN
        test_abort();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/ascon_ctrl_fsm.md
Name: ascon_ctrl_fsm

Overview:
Sequencing FSM for one ASCON-128 encryption. It drives the round counter (compteur_Nbits) through its en/init inputs and consumes the count it returns. From that count it produces round-constant indices, permutation-enable strobes, state-load and key-XOR strobes, and a block-level ready/valid handshake toward the datapath feeding the ASCON state register.

Parameters:
N_BITS, 5, counter output width is N_BITS+1; must match the round counter instance
ROUNDS_A, 12, rounds of p^a (initialisation, finalisation); legal range 1..12
ROUNDS_B, 6, rounds of p^b (between blocks); legal range 1..ROUNDS_A

Ports:
clock_i  in  1  system clock, rising edge
reset_i  in  1  reset, synchronous, active-high
start_i  in  1  request a new encryption; sampled in IDLE only
block_valid_i  in  1  datapath presents a rate block
block_last_i  in  1  presented block is the last one; qualified by block_valid_i
block_ready_o  out  1  FSM accepts a block this cycle
cpt_i  in  N_BITS+1  current round counter value
cpt_en_o  out  1  round counter enable
cpt_init_o  out  1  round counter clear (with cpt_en_o)
round_o  out  4  round-constant index for the current permutation round
perm_en_o  out  1  apply one permutation round to the state this cycle
state_load_o  out  1  load IV||K||N into the state
key_xor_init_o  out  1  XOR 0*||K after initialisation
data_xor_o  out  1  XOR the accepted block into the rate
key_xor_final_o  out  1  XOR K before finalisation
busy_o  out  1  FSM not in IDLE
done_o  out  1  one-cycle pulse: tag available in state

Behaviour:
- States: IDLE, LOAD, INIT_R, INIT_KEY, WAIT_BLK, MID_R, FIN_KEY, FIN_R, TAG.
- Reset: synchronous. reset_i=1 forces IDLE at the next edge, regardless of state. Every output is 0 in IDLE. No strobe or done_o pulse is emitted on a reset mid-operation.
- All outputs are Moore-decoded from the state, except data_xor_o and block_ready_o, as noted below.
- IDLE: busy_o=0, cpt_en_o=0. start_i=1 moves to LOAD. start_i is ignored in every other state.
- LOAD (1 cycle): state_load_o=1, cpt_en_o=1, cpt_init_o=1. Next state INIT_R.
- INIT_R: perm_en_o=1, cpt_en_o=1, cpt_init_o=0, round_o=cpt_i[3:0]+(12-ROUNDS_A). Leaves for INIT_KEY when cpt_i >= ROUNDS_A-1. The ">=" comparison guards against a runaway counter.
- INIT_KEY (1 cycle): key_xor_init_o=1, cpt_en_o=1, cpt_init_o=1. Next state WAIT_BLK.
- WAIT_BLK:
  - block_ready_o=1, cpt_en_o=1, cpt_init_o=1 (counter held at 0).
  - Transfer occurs when block_valid_i && block_ready_o. In that cycle data_xor_o=1 (combinational on block_valid_i).
  - After a transfer: block_last_i=0 goes to MID_R; block_last_i=1 goes to FIN_KEY.
  - No transfer means the FSM stays in WAIT_BLK indefinitely with no perm_en_o.
- MID_R: perm_en_o=1, cpt_en_o=1, round_o=cpt_i[3:0]+(12-ROUNDS_B). Leaves for WAIT_BLK when cpt_i >= ROUNDS_B-1.
- FIN_KEY (1 cycle): key_xor_final_o=1, cpt_en_o=1, cpt_init_o=1. Next state FIN_R.
- FIN_R: same as INIT_R, ending in TAG.
- TAG (1 cycle): done_o=1, busy_o=1. Next state IDLE.
- busy_o=1 in every state except IDLE.
- Latency with defaults, start_i accepted at edge 0:
  - LOAD in cycle 1, INIT_R in cycles 2-13, INIT_KEY in cycle 14, first block_ready_o in cycle 15.
  - Non-last block accepted in cycle t: MID_R in t+1..t+6, WAIT_BLK in t+7.
  - Last block accepted in cycle t: FIN_KEY in t+1, FIN_R in t+2..t+13, done_o in t+14, IDLE in t+15.
- round_o is 0 outside the round states.

Optional Feature:
ASCON_CTRL_ABORT_EN:
- Defined: adds input abort_i (1 bit). abort_i=1 in any non-IDLE state returns the FSM to IDLE at the next edge, with no done_o. During that cycle cpt_en_o=1 and cpt_init_o=1 so the counter is cleared. reset_i has priority over abort_i.
- Not defined: the port is absent and only reset_i can terminate an operation.

Test Plan:
- Reset: reset_i=1 for 3 cycles with start_i=1 -> every output 0, busy_o=0. Deassert reset -> IDLE; start_i then accepted.
- Single last block, valid already high: start at edge 0 ->
  - state_load_o in cycle 1
  - perm_en_o in cycles 2-13 with round_o 0..11
  - key_xor_init_o in cycle 14
  - data_xor_o in cycle 15
  - key_xor_final_o in cycle 16
  - round_o 0..11 in cycles 17-28
  - done_o only in cycle 29; busy_o=0 from cycle 30.
- Two blocks (first non-last accepted in cycle 15) -> perm_en_o in cycles 16-21 with round_o 6..11, block_ready_o again in cycle 22. Second block (last) gives done_o 14 cycles after its acceptance.
- Backpressure: block_valid_i=0 for 10 cycles in WAIT_BLK -> block_ready_o=1 throughout, perm_en_o=0, data_xor_o=0, cpt_init_o=1.
- Reset asserted in cycle 20 of FIN_R -> IDLE at the next edge, no done_o. Fresh start reproduces the exact timing of the single-last-block scenario.
- start_i held high for the whole operation -> exactly one done_o. The FSM restarts (LOAD) the cycle after returning to IDLE; with ASCON_CTRL_ABORT_EN, abort_i in cycle 5 -> IDLE in cycle 6, no done_o.
